rom_stream_ctrl: RTL and testbench
==================================

Name: rom_stream_ctrl

Overview:
- Sequencer that drains the shared 58-word coefficient/activation ROM into the PE array as one ordered stream.
- ROM layout: 7x7 ifmap at addresses 0..48, 3x3 filter at 49..57; 16-bit words; registered read with 1-cycle latency.
- On `start`, the block streams the filter first, then the ifmap, over a valid/ready interface.
- Each beat carries a phase tag and row/col indices. Backpressure is absorbed by a small FIFO, so the ROM never needs stalling.

Parameters:
- DATA_W, 16, ROM word width
- ADDR_W, 6, ROM address width
- IFMAP_BASE, 0, first ifmap address
- IFMAP_DIM, 7, ifmap rows = cols
- FILT_BASE, 49, first filter address
- FILT_DIM, 3, filter rows = cols
- FIFO_DEPTH, 4, output buffer entries (power of 2, ≥4)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; begin a pass; ignored while busy
- abort  in  1  synchronous flush; returns to IDLE, no done pulse
- rom_read  out  1  ROM read strobe
- rom_addr  out  ADDR_W  ROM address
- rom_dout  in  DATA_W  ROM data, valid the cycle after rom_read=1
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_data  out  DATA_W  word
- out_is_filt  out  1  1 = filter word, 0 = ifmap word
- out_row  out  3  row index within current matrix
- out_col  out  3  col index within current matrix
- out_last  out  1  final beat of current phase (filter word 9, ifmap word 49)
- busy  out  1  pass in progress (state ≠ IDLE, or FIFO non-empty)
- done  out  1  one-cycle pulse after the final ifmap beat is accepted

Behaviour:
- Reset (rst=0 at a clock edge) applies regardless of state:
  - rom_read=0, rom_addr=0, out_valid=0, out_last=0, out_is_filt=0, out_row=0, out_col=0, busy=0, done=0.
  - FIFO and all counters cleared; state=IDLE.
- FSM states: IDLE, FILT, IFMAP, DRAIN.
  - IDLE: start=1 → FILT.
  - FILT: issue addresses FILT_BASE..FILT_BASE+8 row-major; after issuing the 9th → IFMAP.
  - IFMAP: issue IFMAP_BASE..IFMAP_BASE+48; after issuing the 49th → DRAIN.
  - DRAIN: wait until FIFO is empty and no read is outstanding, then pulse done for one cycle → IDLE.
- rom_read and rom_addr are registered.
  - A read is issued only if FIFO occupancy, plus reads in flight, plus the new read, minus a pop this cycle, is at most FIFO_DEPTH.
  - FIFO never overflows; rom_dout is always captured the cycle after rom_read=1.
  - When no read is issued, rom_read=0 and rom_addr holds its last value.
- Each FIFO entry stores data, is_filt, row, col and last; these are captured alongside the read issue and delayed to match the ROM latency.
- Output is the FIFO head. A beat transfers when out_valid & out_ready. out_valid stays high, with all out_* stable, until the transfer.
- Latency: start sampled in cycle t → rom_read=1, rom_addr=49 in t+1 → first out_valid in t+3.
- With out_ready held high, throughput is 1 beat/cycle; 58 beats occupy cycles t+3..t+60; done=1 in t+61.
- Row/col counters: col wraps at DIM-1 and increments row. Both return to 0 at a phase change and on start.
- start while busy=1: ignored.
- start coincident with the done cycle: ignored. A new pass needs start while state=IDLE and done=0.
- abort=1: FSM → IDLE, FIFO flushed, in-flight read discarded, out_valid=0 next cycle, no done. abort takes priority over start in the same cycle.
- rst=0 mid-pass: identical to the reset values above; no partial beats afterwards.

Optional Feature:
- Macro: IFMAP_COLMAJOR_EN.
- Defined:
  - Ifmap addresses are issued column-major (IFMAP_BASE + row + col*IFMAP_DIM... i.e. address = IFMAP_BASE + row*IFMAP_DIM + col, with row incrementing fastest).
  - out_row/out_col still report the true row/col of each word.
  - The filter phase is unchanged.
- Undefined: ifmap is issued row-major, as described above.

Test Plan:
- Free-flow pass:
  - Stimulus: start at t, out_ready=1.
  - Required: out_valid t+3..t+60; beat 1 = 0xFD01 (filt, row 0, col 0, from ROM addr 49); beat 9 = 0xFCFD with out_last=1; beat 10 = 0x0000 (ifmap, row 0, col 0); beat 13 = 0x0757; beat 58 = 0x0000 (row 6, col 6) with out_last=1; done at t+61.
- Backpressure:
  - Stimulus: out_ready toggled 1/0 every cycle, then held 0 for 20 cycles.
  - Required: all 58 beats delivered in order; rom_read stops once FIFO plus in-flight reaches 4; out_data stable while stalled.
- Start while busy:
  - Stimulus: second start at beat 20.
  - Required: ignored; exactly 58 beats and one done pulse.
- Abort:
  - Stimulus: abort at beat 30, then start.
  - Required: out_valid=0 next cycle, no done; new pass begins at beat 1 = 0xFD01.
- Reset mid-pass:
  - Stimulus: rst=0 for 1 cycle during the ifmap phase.
  - Required: all outputs at reset values next cycle; busy=0.
- IFMAP_COLMAJOR_EN defined:
  - Stimulus: one pass.
  - Required: ifmap beat 2 = addr 7 = 0x01A1 (row 1, col 0); beat 8 = addr 1 = 0x0000 (row 0, col 1).

Source files
------------

// File: rtl/rom_stream_ctrl.sv
// rom_stream_ctrl: streams the 3x3 filter and then the 7x7 ifmap out of the shared ROM as one tagged beat stream.
// Optional: define IFMAP_COLMAJOR_EN to issue ifmap reads column-major. Row/col tags stay true in that mode.
module rom_stream_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 6,
    parameter int IFMAP_BASE = 0,
    parameter int IFMAP_DIM  = 7,
    parameter int FILT_BASE  = 49,
    parameter int FILT_DIM   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              rom_read,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_is_filt,
    output logic [2:0]        out_row,
    output logic [2:0]        out_col,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = PW + 2;
    localparam logic [2:0] FMAX = 3'(FILT_DIM - 1);
    localparam logic [2:0] IMAX = 3'(IFMAP_DIM - 1);

    typedef enum logic [1:0] {IDLE, FILT, IFMAP, DRAIN} state_t;
    typedef struct packed {
        logic       filt;
        logic [2:0] row;
        logic [2:0] col;
        logic       last;
    } tag_t;
    typedef struct packed {
        logic [DATA_W-1:0] data;
        tag_t              tag;
    } entry_t;

    state_t            state, nstate;
    logic [2:0]        row, col, row_n, col_n;
    logic              issue, ph_filt, can_issue, pop, push, drained, f_end, i_end;
    logic [ADDR_W-1:0] iss_addr;
    tag_t              iss_tag, tag_q, tag_d1;
    logic              rd_d1;
    entry_t            mem [FIFO_DEPTH];
    entry_t            head;
    logic [PW-1:0]     wptr, rptr;
    logic [PW:0]       cnt;
    logic [OW-1:0]     occ_nxt;

    assign ph_filt = (state == IDLE) || (state == FILT);
    assign f_end   = (row == FMAX) && (col == FMAX);
    assign i_end   = (row == IMAX) && (col == IMAX);
    assign iss_addr = ph_filt
        ? ADDR_W'(FILT_BASE)  + ADDR_W'(row) * ADDR_W'(FILT_DIM)  + ADDR_W'(col)
        : ADDR_W'(IFMAP_BASE) + ADDR_W'(row) * ADDR_W'(IFMAP_DIM) + ADDR_W'(col);
    assign iss_tag = '{filt: ph_filt, row: row, col: col, last: (ph_filt ? f_end : i_end)};

    // Every read already issued or about to be issued is charged against FIFO space,
    // so the ROM never has to stall and the FIFO never overflows.
    assign pop       = out_valid & out_ready;
    assign push      = rd_d1 & ~abort;
    assign occ_nxt   = OW'(cnt) + OW'(rd_d1) + OW'(rom_read) + OW'(1) - OW'(pop);
    assign can_issue = occ_nxt <= OW'(FIFO_DEPTH);
    assign drained   = (cnt == '0) && !rom_read && !rd_d1;

    always_comb begin
        nstate = state;
        issue  = 1'b0;
        done   = 1'b0;
        row_n  = row;
        col_n  = col;
        unique case (state)
            IDLE: if (start && can_issue) begin
                issue  = 1'b1;
                nstate = FILT;
            end
            FILT: begin
                issue = can_issue;
                if (issue && f_end) nstate = IFMAP;
            end
            IFMAP: begin
                issue = can_issue;
                if (issue && i_end) nstate = DRAIN;
            end
            DRAIN: if (drained) begin
                done   = 1'b1;
                nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
        // Both counters wrap to zero on the last word, which doubles as the phase reset.
        if (issue) begin
            if (ph_filt) begin
                col_n = (col == FMAX) ? 3'd0 : col + 3'd1;
                if (col == FMAX) row_n = (row == FMAX) ? 3'd0 : row + 3'd1;
            end else begin
`ifdef IFMAP_COLMAJOR_EN
                row_n = (row == IMAX) ? 3'd0 : row + 3'd1;
                if (row == IMAX) col_n = (col == IMAX) ? 3'd0 : col + 3'd1;
`else
                col_n = (col == IMAX) ? 3'd0 : col + 3'd1;
                if (col == IMAX) row_n = (row == IMAX) ? 3'd0 : row + 3'd1;
`endif
            end
        end
        if (abort) begin
            nstate = IDLE;
            issue  = 1'b0;
            done   = 1'b0;
            row_n  = 3'd0;
            col_n  = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            row   <= 3'd0;
            col   <= 3'd0;
        end else begin
            state <= nstate;
            row   <= row_n;
            col   <= col_n;
        end
    end

    // Tags ride two register stages so they meet rom_dout at FIFO write time.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rom_read <= 1'b0;
            rom_addr <= '0;
            tag_q    <= '0;
            rd_d1    <= 1'b0;
            tag_d1   <= '0;
        end else begin
            rom_read <= issue;
            if (issue) begin
                rom_addr <= iss_addr;
                tag_q    <= iss_tag;
            end
            rd_d1  <= rom_read & ~abort;
            tag_d1 <= tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || abort) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= '{data: rom_dout, tag: tag_d1};
    end

    assign head        = mem[rptr];
    assign out_valid   = (cnt != '0);
    assign out_data    = out_valid ? head.data : '0;
    assign out_is_filt = out_valid & head.tag.filt;
    assign out_row     = out_valid ? head.tag.row : 3'd0;
    assign out_col     = out_valid ? head.tag.col : 3'd0;
    assign out_last    = out_valid & head.tag.last;
    assign busy        = (state != IDLE) || out_valid;
endmodule

// File: tb/tb_rom_stream_ctrl.sv
// Directed bench for rom_stream_ctrl: a checkpoint table for a free-flowing pass plus hand sequences
// for backpressure, start-while-busy, abort and mid-pass reset, with an in-order beat scoreboard.
module tb_rom_stream_ctrl;
    typedef struct packed {
        logic [15:0] data;
        logic        filt;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        last;
    } beat_t;

    typedef struct {
        int          cyc;
        logic        rd;
        logic [5:0]  addr;
        logic        valid;
        logic [15:0] data;
        logic        filt;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        last;
        logic        done;
        logic        busy;
    } vec_t;

    localparam int NV = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic        rom_read;
    logic [5:0]  rom_addr;
    logic [15:0] rom_dout = '0;
    logic        out_valid, out_is_filt, out_last, busy, done;
    logic [15:0] out_data;
    logic [2:0]  out_row, out_col;

    logic [15:0] rom_mem [64];
    vec_t        vt [NV];
    int          n_chk = 0, n_fail = 0;
    int          beat_n = 0, done_n = 0, rd_n = 0;
    logic        stall_q = 1'b0;
    logic [15:0] data_q = '0;

    rom_stream_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .rom_read(rom_read), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_is_filt(out_is_filt), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_read) rom_dout <= rom_mem[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (beat %0d, t=%0t)", name, act, exp, beat_n, $time);
        end
    endtask

    function automatic beat_t exp_beat(input int k);
        beat_t b;
        int r, c, a, j;
        if (k < 9) begin
            r = k / 3; c = k % 3; a = 49 + k;
            b.filt = 1'b1; b.last = (k == 8);
        end else begin
            j = k - 9;
`ifdef IFMAP_COLMAJOR_EN
            r = j % 7; c = j / 7;
`else
            r = j / 7; c = j % 7;
`endif
            a = r * 7 + c;
            b.filt = 1'b0; b.last = (j == 48);
        end
        b.row  = 3'(r);
        b.col  = 3'(c);
        b.data = rom_mem[a[5:0]];
        return b;
    endfunction

    // One clock: scoreboard on the falling edge, then step to just after the next rising edge.
    task automatic cyc();
        beat_t eb;
        @(negedge clk);
        if (stall_q) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(data_q));
        end
        if (rom_read === 1'b1) begin
            rd_n++;
            check("outstanding_le4", 32'((rd_n - beat_n) <= 4), 32'd1);
        end
        if (out_valid === 1'b1 && out_ready) begin
            if (beat_n < 58) begin
                eb = exp_beat(beat_n);
                check("beat_data", 32'(out_data), 32'(eb.data));
                check("beat_filt", 32'(out_is_filt), 32'(eb.filt));
                check("beat_row", 32'(out_row), 32'(eb.row));
                check("beat_col", 32'(out_col), 32'(eb.col));
                check("beat_last", 32'(out_last), 32'(eb.last));
            end else begin
                check("extra_beat", 32'(beat_n), 32'd57);
            end
            beat_n++;
        end
        if (done === 1'b1) done_n++;
        stall_q = (out_valid === 1'b1) && !out_ready && !abort && rst;
        data_q  = out_data;
        @(posedge clk);
        #1;
    endtask

    task automatic new_pass();
        beat_n = 0; done_n = 0; rd_n = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int g = 0;
        while (beat_n < n && g < 300) begin cyc(); g++; end
        check("wait_beats_timeout", 32'(beat_n >= n), 32'd1);
    endtask

    task automatic wait_done();
        int g = 0;
        while (done_n == 0 && g < 300) begin cyc(); g++; end
        check("wait_done_timeout", 32'(done_n), 32'd1);
    endtask

    task automatic chk_reset(input string pfx);
        check({pfx, "_rom_read"}, 32'(rom_read), 32'd0);
        check({pfx, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check({pfx, "_valid"}, 32'(out_valid), 32'd0);
        check({pfx, "_last"}, 32'(out_last), 32'd0);
        check({pfx, "_filt"}, 32'(out_is_filt), 32'd0);
        check({pfx, "_row"}, 32'(out_row), 32'd0);
        check({pfx, "_col"}, 32'(out_col), 32'd0);
        check({pfx, "_busy"}, 32'(busy), 32'd0);
        check({pfx, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int vi;
        for (int a = 0; a < 64; a++) rom_mem[a] = 16'h1000 + 16'(a * 16'h11);
        rom_mem[0]  = 16'h0000; rom_mem[1]  = 16'h0000; rom_mem[3]  = 16'h0757;
        rom_mem[7]  = 16'h01A1; rom_mem[48] = 16'h0000;
        rom_mem[49] = 16'hFD01; rom_mem[57] = 16'hFCFD;

        // Checkpoints relative to the start cycle t: {cyc, rd, addr, valid, data, filt, row, col, last, done, busy}
        vt[0]  = '{1,  1'b1, 6'd49, 1'b0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1};
        vt[1]  = '{2,  1'b1, 6'd50, 1'b0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1};
        vt[2]  = '{3,  1'b1, 6'd51, 1'b1, 16'hFD01, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{12, 1'b1, 6'd2,  1'b1, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1};
        vt[9]  = '{60, 1'b0, 6'd0,  1'b1, 16'h0000, 1'b0, 3'd6, 3'd6, 1'b1, 1'b0, 1'b1};
        vt[10] = '{61, 1'b0, 6'd0,  1'b0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1};
        vt[11] = '{62, 1'b0, 6'd0,  1'b0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};
`ifdef IFMAP_COLMAJOR_EN
        vt[3]  = '{11, 1'b1, 6'd7,  1'b1, 16'hFCFD, 1'b1, 3'd2, 3'd2, 1'b1, 1'b0, 1'b1};
        vt[4].addr = 6'd14;
        vt[5]  = '{13, 1'b1, 6'd21, 1'b1, 16'h01A1, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{15, 1'b1, 6'd35, 1'b1, 16'h1165, 1'b0, 3'd3, 3'd0, 1'b0, 1'b0, 1'b1};
        vt[7]  = '{19, 1'b1, 6'd15, 1'b1, 16'h0000, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1};
        vt[8]  = '{58, 1'b1, 6'd48, 1'b1, 16'h1242, 1'b0, 3'd4, 3'd6, 1'b0, 1'b0, 1'b1};
`else
        vt[3]  = '{11, 1'b1, 6'd1,  1'b1, 16'hFCFD, 1'b1, 3'd2, 3'd2, 1'b1, 1'b0, 1'b1};
        vt[5]  = '{13, 1'b1, 6'd3,  1'b1, 16'h0000, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{15, 1'b1, 6'd5,  1'b1, 16'h0757, 1'b0, 3'd0, 3'd3, 1'b0, 1'b0, 1'b1};
        vt[7]  = '{19, 1'b1, 6'd9,  1'b1, 16'h01A1, 1'b0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1};
        vt[8]  = '{58, 1'b1, 6'd48, 1'b1, 16'h130E, 1'b0, 3'd6, 3'd4, 1'b0, 1'b0, 1'b1};
`endif

        // Reset state
        cyc(); cyc();
        chk_reset("reset");
        rst = 1'b1;
        cyc();

        // Free-flow pass against the checkpoint table
        out_ready = 1'b1;
        new_pass();
        vi = 0;
        for (int c = 1; c <= 62; c++) begin
            if (vi < NV && vt[vi].cyc == c) begin
                check("ff_rom_read", 32'(rom_read), 32'(vt[vi].rd));
                if (vt[vi].rd) check("ff_rom_addr", 32'(rom_addr), 32'(vt[vi].addr));
                check("ff_valid", 32'(out_valid), 32'(vt[vi].valid));
                if (vt[vi].valid) begin
                    check("ff_data", 32'(out_data), 32'(vt[vi].data));
                    check("ff_filt", 32'(out_is_filt), 32'(vt[vi].filt));
                    check("ff_row", 32'(out_row), 32'(vt[vi].row));
                    check("ff_col", 32'(out_col), 32'(vt[vi].col));
                    check("ff_last", 32'(out_last), 32'(vt[vi].last));
                end
                check("ff_done", 32'(done), 32'(vt[vi].done));
                check("ff_busy", 32'(busy), 32'(vt[vi].busy));
                vi++;
            end
            cyc();
        end
        check("ff_beats", 32'(beat_n), 32'd58);
        check("ff_dones", 32'(done_n), 32'd1);

        // Backpressure: alternate ready, then stall hard until the FIFO and pipe are full
        new_pass();
        for (int i = 0; i < 40; i++) begin
            out_ready = i[0];
            cyc();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) cyc();
        check("bp_stalled_valid", 32'(out_valid), 32'd1);
        check("bp_rom_read_off", 32'(rom_read), 32'd0);
        check("bp_outstanding", 32'(rd_n - beat_n), 32'd4);
        out_ready = 1'b1;
        wait_done();
        check("bp_beats", 32'(beat_n), 32'd58);
        cyc();

        // Start while busy, and start coincident with done
        new_pass();
        wait_beats(20);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int g = 0; g < 200 && done !== 1'b1; g++) cyc();
        check("sb_done_seen", 32'(done), 32'd1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc(); cyc();
        check("sb_beats", 32'(beat_n), 32'd58);
        check("sb_dones", 32'(done_n), 32'd1);
        check("sb_idle_busy", 32'(busy), 32'd0);
        check("sb_no_read", 32'(rom_read), 32'd0);

        // Abort at beat 30, with a coincident start that must lose to abort
        new_pass();
        wait_beats(30);
        out_ready = 1'b0;
        abort = 1'b1;
        start = 1'b1;
        cyc();
        abort = 1'b0;
        start = 1'b0;
        check("ab_valid", 32'(out_valid), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_rom_read", 32'(rom_read), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        check("ab_no_late_beat", 32'(out_valid), 32'd0);
        check("ab_no_done", 32'(done_n), 32'd0);
        new_pass();
        wait_done();
        check("ab_restart_beats", 32'(beat_n), 32'd58);
        cyc();

        // Reset in the middle of the ifmap phase
        new_pass();
        wait_beats(15);
        out_ready = 1'b0;
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        chk_reset("midrst");
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        check("midrst_no_beat", 32'(out_valid), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
